// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit with HI/LO registers and a fixed-latency busy window.
// Results are formed from operands latched at accept, so the arithmetic is a multicycle path bounded by the busy count.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiLoWr,
  input  logic        UseMD,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]     r_a, r_b;
  logic [1:0]      r_op;
  logic [31:0]     r_hi, r_lo;

  logic            w_idle, w_accept, w_done;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = Start & w_idle & ~MDOp[2];
  assign w_done   = (r_state == S_BUSY) & (r_cnt == CW'(1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_op <= '0;
    end else if (w_accept) begin
      r_a  <= A;
      r_b  <= B;
      r_op <= MDOp[1:0];
    end
  end

  // One 64x64 multiplier serves both signednesses: sign- or zero-extend, keep the low 64 bits.
  logic        w_sgn;
  logic [63:0] w_mop_a, w_mop_b, w_prod;

  assign w_sgn   = ~r_op[0];
  assign w_mop_a = {(w_sgn ? {32{r_a[31]}} : 32'd0), r_a};
  assign w_mop_b = {(w_sgn ? {32{r_b[31]}} : 32'd0), r_b};
  assign w_prod  = w_mop_a * w_mop_b;

  // Signed divide on magnitudes; -2^31 / -1 wraps back to 0x80000000 on its own.
  logic        w_neg_a, w_neg_b, w_neg_q, w_b_nz;
  logic [31:0] w_mag_a, w_mag_b, w_uq, w_ur, w_quo, w_rem;

  assign w_neg_a = w_sgn & r_a[31];
  assign w_neg_b = w_sgn & r_b[31];
  assign w_neg_q = w_neg_a ^ w_neg_b;
  assign w_mag_a = w_neg_a ? (~r_a + 32'd1) : r_a;
  assign w_mag_b = w_neg_b ? (~r_b + 32'd1) : r_b;
  assign w_b_nz  = |r_b;
  assign w_uq    = w_b_nz ? (w_mag_a / w_mag_b) : 32'd0;
  assign w_ur    = w_b_nz ? (w_mag_a % w_mag_b) : 32'd0;
  assign w_quo   = w_neg_q ? (~w_uq + 32'd1) : w_uq;
  assign w_rem   = w_neg_a ? (~w_ur + 32'd1) : w_ur;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (!r_op[1]) begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end else if (w_b_nz) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end
    end else if (HiLoWr && w_idle) begin
      if (MDOp == 3'd4) r_hi <= A;
      if (MDOp == 3'd5) r_lo <= A;
    end
  end

  assign Busy  = (r_state == S_BUSY);
  assign Stall = UseMD & (Busy | Start);
  assign HI    = r_hi;
  assign LO    = r_lo;
endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vector table, randomized ops against a plain-arithmetic model, corner sequences.
module tb_mul_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        Clock = 1'b0;
  logic        Reset, Start, HiLoWr, UseMD;
  logic [2:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy, Stall;
  logic [31:0] HI, LO;

  int total = 0;
  int bad   = 0;

  mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .HiLoWr(HiLoWr), .UseMD(UseMD), .Busy(Busy), .Stall(Stall), .HI(HI), .LO(LO)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        usemd, inject;
    logic [31:0] hi, lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: result of one op given the current HI/LO, straight from the arithmetic rules.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] hi, input logic [31:0] lo);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0]     res;
    res = {hi, lo};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin p = longint'(sa * sb); res = p; end
      3'd1: begin p = ua * ub; res = p; end
      3'd2: if (b != 0) begin
        q = sa / sb; r = sa % sb;
        res = {r[31:0], q[31:0]};
      end
      3'd3: if (b != 0) res = {a % b, a / b};
      default: ;
    endcase
    return res;
  endfunction

  // Issue one op, optionally poke Start+MTLO mid-flight, then check busy length, Stall and HI/LO.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic usemd, input logic inject, input logic [63:0] exp);
    int n, expn;
    expn = op[1] ? DC : MC;
    @(negedge Clock);
    Start = 1'b1; MDOp = op; A = a; B = b; UseMD = usemd; HiLoWr = 1'b0;
    #1 chk({name, " stall_start"}, Stall, usemd);
    @(negedge Clock);
    Start = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    while (Busy && n < 100) begin
      chk({name, " stall_busy"}, Stall, usemd);
      n++;
      if (inject && n == 2) begin
        Start = 1'b1; HiLoWr = 1'b1; MDOp = 3'd5; A = $urandom;
      end else if (inject && n == 3) begin
        Start = 1'b1; HiLoWr = 1'b0; MDOp = 3'd0; A = $urandom;
      end else begin
        Start = 1'b0; HiLoWr = 1'b0;
      end
      @(negedge Clock);
    end
    chk({name, " busy_cycles"}, n, expn);
    chk({name, " stall_after"}, Stall, 1'b0);
    chk({name, " hilo"}, {HI, LO}, exp);
  endtask

  vec_t vt[9];
  logic [63:0] m;

  initial begin
    vt[0] = '{3'd0, 32'hFFFFFFFE, 32'd3,        1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vt[1] = '{3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vt[2] = '{3'd3, 32'd7,        32'd2,        1'b1, 1'b0, 32'd1,        32'd3};
    vt[3] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'hFFFFFFFE, 32'h00000001};
    vt[4] = '{3'd3, 32'd1234,     32'd0,        1'b1, 1'b0, 32'hFFFFFFFE, 32'h00000001};
    vt[5] = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h80000000};
    vt[6] = '{3'd2, 32'd7,        32'hFFFFFFFE, 1'b1, 1'b1, 32'h00000001, 32'hFFFFFFFD};
    vt[7] = '{3'd0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h40000000, 32'h00000000};
    vt[8] = '{3'd2, 32'd99,       32'd0,        1'b0, 1'b0, 32'h40000000, 32'h00000000};

    Reset = 1'b1; Start = 1'b0; HiLoWr = 1'b0; UseMD = 1'b1; MDOp = 3'd7; A = '0; B = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("reset busy", Busy, 1'b0);
    chk("reset hilo", {HI, LO}, 64'd0);
    chk("reset stall", Stall, 1'b0);

    foreach (vt[i])
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].usemd, vt[i].inject, {vt[i].hi, vt[i].lo});

    m = {HI, LO};
    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 3));
      a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        2:       b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      m = model(op, a, b, m[63:32], m[31:0]);
      run_op($sformatf("rnd%0d", i), op, a, b, 1'($urandom), 1'($urandom), m);
    end

    // Start+MTHI together while idle: the direct write wins, nothing launches.
    @(negedge Clock);
    Start = 1'b1; HiLoWr = 1'b1; MDOp = 3'd4; A = 32'h12345678;
    @(negedge Clock);
    Start = 1'b0; HiLoWr = 1'b0; A = 32'hDEADBEEF;
    chk("mthi hi", HI, 32'h12345678);
    chk("mthi busy", Busy, 1'b0);
    HiLoWr = 1'b1; MDOp = 3'd5; A = 32'hCAFEF00D;
    @(negedge Clock);
    HiLoWr = 1'b0;
    chk("mtlo lo", LO, 32'hCAFEF00D);
    chk("mtlo hi kept", HI, 32'h12345678);

    // Reset during the third busy cycle of a DIV aborts it for good.
    Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
    @(negedge Clock);
    Start = 1'b0;
    repeat (2) @(negedge Clock);
    chk("mid busy", Busy, 1'b1);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    chk("abort busy", Busy, 1'b0);
    chk("abort hilo", {HI, LO}, 64'd0);
    repeat (DC + 2) @(negedge Clock);
    chk("abort no commit", {HI, LO}, 64'd0);
    chk("abort idle", Busy, 1'b0);

    UseMD = 1'b0;
    run_op("final mult", 3'd0, 32'd6, 32'hFFFFFFF9, 1'b0, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFD6});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
